// File: rtl/bellek_bekleme_denetleyici.sv
// bellek_bekleme_denetleyici
// Wait-state memory controller between the processor (islemci) and a
// single-cycle memory array (anabellek). One request is accepted at a time,
// held for a programmable number of wait cycles, then performed in one cycle;
// completion is signalled by a one-cycle islemci_hazir pulse.
// Build option: define RASTGELE_GECIKME_EN to add 0..3 pseudo-random extra
// wait cycles per access, drawn from a 16-bit Galois LFSR.

module bellek_bekleme_denetleyici #(
   parameter int          ADRES_BIT  = 32,
   parameter int          VERI_BIT   = 32,
   parameter int          BEKLEME    = 3,
   parameter logic [15:0] LFSR_TOHUM = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 islemci_istek,
   input  logic                 islemci_yaz,
   input  logic [ADRES_BIT-1:0] islemci_adres,
   input  logic [VERI_BIT-1:0]  islemci_yaz_veri,
   output logic [VERI_BIT-1:0]  islemci_oku_veri,
   output logic                 islemci_hazir,
   output logic                 mesgul,
   output logic [ADRES_BIT-1:0] bellek_adres,
   output logic [VERI_BIT-1:0]  bellek_yaz_veri,
   output logic                 bellek_yaz,
   input  logic [VERI_BIT-1:0]  bellek_oku_veri
);

   // Address register comes out of reset pointing at the base of main memory
   localparam logic [ADRES_BIT-1:0] ADRES_SIFIR = ADRES_BIT'(64'h0000_0000_8000_0000);
   localparam logic [4:0]           BEKLEME_5   = 5'(BEKLEME);

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      BEKLE = 2'd1,
      TAMAM = 2'd2
   } durum_t;

   durum_t                r_durum;
   logic [4:0]            r_sayac;
   logic                  r_yaz;
   logic [ADRES_BIT-1:0]  r_adres;
   logic [VERI_BIT-1:0]   r_yaz_veri;
   logic [VERI_BIT-1:0]   r_oku_veri;
   logic                  r_hazir;
   logic                  r_mesgul;

   logic [1:0]            w_ek;
   logic [4:0]            w_yukle;
   logic                  w_erisim;

`ifdef RASTGELE_GECIKME_EN
   logic [15:0] r_lfsr;

   // Free-running Galois LFSR (x^16+x^14+x^13+x^11+1); restarts from the seed on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_TOHUM;
      end else begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign w_ek = r_lfsr[1:0];
`else
   // Without random latency the seed has no effect; the extra term is always zero
   assign w_ek = LFSR_TOHUM[1:0] & 2'b00;
`endif

   // Counter load value: at most 15 + 3 = 18, fits the 5-bit counter without wrap
   assign w_yukle  = BEKLEME_5 + {3'b000, w_ek};

   // The single access cycle: last wait cycle of BEKLE
   assign w_erisim = (r_durum == BEKLE) && (r_sayac == 5'd0);

   assign bellek_yaz       = w_erisim && r_yaz;
   assign bellek_adres     = r_adres;
   assign bellek_yaz_veri  = r_yaz_veri;
   assign islemci_oku_veri = r_oku_veri;
   assign islemci_hazir    = r_hazir;
   assign mesgul           = r_mesgul;

   // Request FSM: accept in BOSTA, count down in BEKLE, pulse hazir in TAMAM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_durum    <= BOSTA;
         r_sayac    <= 5'd0;
         r_yaz      <= 1'b0;
         r_adres    <= ADRES_SIFIR;
         r_yaz_veri <= '0;
         r_oku_veri <= '0;
         r_hazir    <= 1'b0;
         r_mesgul   <= 1'b0;
      end else begin
         case (r_durum)
            BOSTA: begin
               r_hazir <= 1'b0;
               if (islemci_istek) begin
                  // Acceptance edge: everything the access needs is frozen here
                  r_adres    <= islemci_adres;
                  r_yaz      <= islemci_yaz;
                  r_yaz_veri <= islemci_yaz_veri;
                  r_sayac    <= w_yukle;
                  r_mesgul   <= 1'b1;
                  r_durum    <= BEKLE;
               end
            end
            BEKLE: begin
               if (r_sayac != 5'd0) begin
                  r_sayac <= r_sayac - 5'd1;
               end else begin
                  // Memory read data is combinational, so it is valid in this cycle
                  if (!r_yaz) begin
                     r_oku_veri <= bellek_oku_veri;
                  end
                  r_hazir <= 1'b1;
                  r_durum <= TAMAM;
               end
            end
            TAMAM: begin
               // Requests presented during this cycle are deliberately not seen
               r_hazir  <= 1'b0;
               r_mesgul <= 1'b0;
               r_durum  <= BOSTA;
            end
            default: begin
               r_hazir  <= 1'b0;
               r_mesgul <= 1'b0;
               r_durum  <= BOSTA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bellek_bekleme_denetleyici.sv
// Testbench for bellek_bekleme_denetleyici.
// Two instances: u0 with BEKLEME=3 and u1 with BEKLEME=0, each with its own
// memory array. A cycle-index model predicts every output from the latency
// rules; directed sequences add literal expectations on top.
// With RASTGELE_GECIKME_EN defined, the random-latency sequence is checked instead.

module tb_bellek_bekleme_denetleyici;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;

   always #5 clk = ~clk;

   logic        istek  [2];
   logic        yaz    [2];
   logic [31:0] adres  [2];
   logic [31:0] wdata  [2];
   logic [31:0] oku    [2];
   logic        hazir  [2];
   logic        mesgul [2];
   logic [31:0] badres [2];
   logic [31:0] bwdata [2];
   logic        byaz   [2];
   logic [31:0] boku   [2];

   logic [31:0] mem       [2][1024];
   logic [31:0] model_mem [2][1024];

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input int j);
      case (j)
         'h080:   return 32'h0000_0200;
         'h081:   return 32'h0000_0400;
         'h082:   return 32'h0000_0800;
         'h083:   return 32'h0000_0C00;
         'h084:   return 32'h0000_1000;
         'h0C0:   return 32'h0BAD_0300;
         'h100:   return 32'hA5A5_A5A5;
         default: return 32'hC0DE_0000 | 32'(j);
      endcase
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int B = (gi == 0) ? 3 : 0;

      bellek_bekleme_denetleyici #(
         .ADRES_BIT (32),
         .VERI_BIT  (32),
         .BEKLEME   (B),
         .LFSR_TOHUM(16'hACE1)
      ) u_dut (
         .clk             (clk),
         .rst             (rst),
         .islemci_istek   (istek[gi]),
         .islemci_yaz     (yaz[gi]),
         .islemci_adres   (adres[gi]),
         .islemci_yaz_veri(wdata[gi]),
         .islemci_oku_veri(oku[gi]),
         .islemci_hazir   (hazir[gi]),
         .mesgul          (mesgul[gi]),
         .bellek_adres    (badres[gi]),
         .bellek_yaz_veri (bwdata[gi]),
         .bellek_yaz      (byaz[gi]),
         .bellek_oku_veri (boku[gi])
      );

      // anabellek: combinational read, write on the strobe
      assign boku[gi] = mem[gi][badres[gi][11:2]];

      always @(posedge clk) begin
         if (mem_init) begin
            for (int j = 0; j < 1024; j++) mem[gi][j] <= init_val(j);
         end else if (byaz[gi]) begin
            mem[gi][badres[gi][11:2]] <= bwdata[gi];
         end
      end

      // Model: ec counts edges since reset; acc is the edge a request was accepted.
      // Access occupies edges acc..acc+B+1; next acceptance allowed at acc+B+3.
      int          ec;
      int          acc;
      logic        m_wr;
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic [31:0] m_rdata;

      always @(posedge clk or posedge rst) begin
         if (mem_init) begin
            for (int j = 0; j < 1024; j++) model_mem[gi][j] <= init_val(j);
         end
         if (rst) begin
            ec      <= 0;
            acc     <= -100;
            m_wr    <= 1'b0;
            m_addr  <= 32'h8000_0000;
            m_wdata <= 32'h0;
            m_rdata <= 32'h0;
         end else begin
            ec <= ec + 1;
            if ((ec + 1 >= acc + B + 3) && istek[gi]) begin
               acc     <= ec + 1;
               m_addr  <= adres[gi];
               m_wr    <= yaz[gi];
               m_wdata <= wdata[gi];
            end
            if (ec + 1 == acc + B + 1) begin
               if (m_wr) model_mem[gi][m_addr[11:2]] <= m_wdata;
               else      m_rdata <= model_mem[gi][m_addr[11:2]];
            end
         end
      end

`ifndef RASTGELE_GECIKME_EN
      always @(negedge clk) begin
         if (!rst && !mem_init) begin
            chk($sformatf("u%0d.hazir e%0d", gi, ec),  32'(hazir[gi]),  32'(ec == acc + B + 1));
            chk($sformatf("u%0d.mesgul e%0d", gi, ec), 32'(mesgul[gi]), 32'((ec >= acc) && (ec <= acc + B + 1)));
            chk($sformatf("u%0d.byaz e%0d", gi, ec),   32'(byaz[gi]),   32'(m_wr && (ec == acc + B)));
            chk($sformatf("u%0d.oku e%0d", gi, ec),    oku[gi],    m_rdata);
            chk($sformatf("u%0d.badres e%0d", gi, ec), badres[gi], m_addr);
            chk($sformatf("u%0d.bwdata e%0d", gi, ec), bwdata[gi], m_wdata);
         end
      end
`endif
   end

   // One access on instance i; called at a negedge with the instance idle.
   // lat = edges from acceptance until hazir is seen; st/sa record write strobes.
   task automatic do_access(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input bit chg, input logic [31:0] ca, input logic [31:0] cd,
                            output int lat, output int st, output logic [31:0] sa);
      istek[i] = 1'b1;
      yaz[i]   = wr;
      adres[i] = a;
      wdata[i] = d;
      lat = 0;
      st  = 0;
      sa  = 32'h0;
      @(negedge clk);
      istek[i] = 1'b0;
      while (!hazir[i] && lat < 40) begin
         if (byaz[i]) begin
            st++;
            sa = badres[i];
         end
         if (chg && lat == 1) begin
            adres[i] = ca;
            wdata[i] = cd;
         end
         @(negedge clk);
         lat++;
      end
      $display("access u%0d wr=%0d adr=%h lat=%0d strobes=%0d oku=%h", i, wr, a, lat, st, oku[i]);
      @(negedge clk);
   endtask

   int          lat, st;
   logic [31:0] sa;

   initial begin
      for (int i = 0; i < 2; i++) begin
         istek[i] = 1'b0;
         yaz[i]   = 1'b0;
         adres[i] = 32'h8000_0000;
         wdata[i] = 32'h0;
      end
      rst      = 1'b1;
      mem_init = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mem_init = 1'b0;
      rst      = 1'b0;

`ifndef RASTGELE_GECIKME_EN
      // Reset values
      chk("rst hazir",  32'(hazir[0]),  32'h0);
      chk("rst mesgul", 32'(mesgul[0]), 32'h0);
      chk("rst byaz",   32'(byaz[0]),   32'h0);
      chk("rst oku",    oku[0],    32'h0);
      chk("rst badres", badres[0], 32'h8000_0000);
      chk("rst bwdata", bwdata[0], 32'h0);

      // Read with BEKLEME=3
      do_access(0, 1'b0, 32'h8000_0200, 32'h0, 1'b0, 32'h0, 32'h0, lat, st, sa);
      chk("t1 latency", 32'(lat), 32'd4);
      chk("t1 data",    oku[0],   32'h0000_0200);
      chk("t1 strobes", 32'(st),  32'd0);

      // Write
      do_access(0, 1'b1, 32'h8000_0300, 32'hFF00_3301, 1'b0, 32'h0, 32'h0, lat, st, sa);
      chk("t2 strobes",     32'(st),     32'd1);
      chk("t2 strobe addr", sa,          32'h8000_0300);
      chk("t2 mem",         mem[0][192], 32'hFF00_3301);
      chk("t2 oku held",    oku[0],      32'h0000_0200);
      do_access(0, 1'b0, 32'h8000_0300, 32'h0, 1'b0, 32'h0, 32'h0, lat, st, sa);
      chk("t2 readback", oku[0], 32'hFF00_3301);

      // Inputs changed mid-BEKLE
      do_access(0, 1'b1, 32'h8000_0300, 32'h1234_5678, 1'b1, 32'h8000_0400, 32'h0, lat, st, sa);
      chk("t4 strobe addr", sa,           32'h8000_0300);
      chk("t4 mem 300",     mem[0][192],  32'h1234_5678);
      chk("t4 mem 400",     mem[0][256],  32'hA5A5_A5A5);

      // BEKLEME=0, five back-to-back reads with istek held
      begin
         logic [31:0] exp_d [5] = '{32'h200, 32'h400, 32'h800, 32'hC00, 32'h1000};
         logic [31:0] adr_l [5] = '{32'h8000_0200, 32'h8000_0204, 32'h8000_0208,
                                    32'h8000_020C, 32'h8000_0210};
         int j   = 0;
         int cyc = 0;
         istek[1] = 1'b1;
         yaz[1]   = 1'b0;
         adres[1] = adr_l[0];
         while (j < 5 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (hazir[1]) begin
               $display("b2b read %0d cyc=%0d oku=%h", j, cyc, oku[1]);
               chk($sformatf("t3 data %0d", j), oku[1],   exp_d[j]);
               chk($sformatf("t3 when %0d", j), 32'(cyc), 32'(3 * j + 2));
               j++;
               if (j < 5) adres[1] = adr_l[j];
               else       istek[1] = 1'b0;
            end
         end
         chk("t3 completed", 32'(j), 32'd5);
         istek[1] = 1'b0;
         @(negedge clk);
      end

      // Reset during BEKLE of a write
      begin
         int bad = 0;
         istek[0] = 1'b1;
         yaz[0]   = 1'b1;
         adres[0] = 32'h8000_0300;
         wdata[0] = 32'hDEAD_0001;
         @(negedge clk);
         istek[0] = 1'b0;
         @(negedge clk);
         chk("t5 busy", 32'(mesgul[0]), 32'h1);
         #2 rst = 1'b1;
         #1;
         chk("t5 hazir",  32'(hazir[0]),  32'h0);
         chk("t5 mesgul", 32'(mesgul[0]), 32'h0);
         chk("t5 byaz",   32'(byaz[0]),   32'h0);
         chk("t5 oku",    oku[0],    32'h0);
         chk("t5 badres", badres[0], 32'h8000_0000);
         chk("t5 bwdata", bwdata[0], 32'h0);
         @(negedge clk);
         rst = 1'b0;
         for (int k = 0; k < 10; k++) begin
            if (byaz[0] || hazir[0]) bad++;
            @(negedge clk);
         end
         $display("reset abort: stray events=%0d mem300=%h", bad, mem[0][192]);
         chk("t5 no strobe/hazir", 32'(bad), 32'd0);
         chk("t5 mem kept", mem[0][192], 32'h1234_5678);
         do_access(0, 1'b0, 32'h8000_0200, 32'h0, 1'b0, 32'h0, 32'h0, lat, st, sa);
         chk("t5 next latency", 32'(lat), 32'd4);
         chk("t5 next data",    oku[0],   32'h0000_0200);
      end

      // Final memory image against the model
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 1024; j++)
            chk($sformatf("mem u%0d[%0d]", i, j), mem[i][j], model_mem[i][j]);
`else
      begin
         int lats [2][32];
         for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
               rst = 1'b1;
               @(negedge clk);
               @(negedge clk);
               rst = 1'b0;
            end
            for (int n = 0; n < 32; n++) begin
               do_access(0, 1'b0, 32'h8000_0200, 32'h0, 1'b0, 32'h0, 32'h0, lat, st, sa);
               lats[r][n] = lat;
               chk($sformatf("rnd range r%0d n%0d", r, n), 32'((lat >= 4) && (lat <= 7)), 32'h1);
            end
         end
         begin
            int distinct = 0;
            bit seen [8];
            for (int v = 0; v < 8; v++) seen[v] = 1'b0;
            for (int n = 0; n < 32; n++) seen[lats[0][n] & 7] = 1'b1;
            for (int v = 0; v < 8; v++) if (seen[v]) distinct++;
            chk("rnd distinct>=2", 32'(distinct >= 2), 32'h1);
         end
         for (int n = 0; n < 32; n++)
            chk($sformatf("rnd repeat n%0d", n), 32'(lats[1][n]), 32'(lats[0][n]));
      end
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   // Absolute time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      errs++;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bellek_bekleme_denetleyici.md
Name: bellek_bekleme_denetleyici

Overview:
- Wait-state memory controller between `islemci` (upstream requester) and `anabellek` (downstream single-cycle array).
- Accepts one processor memory request at a time and holds it for a programmable number of wait cycles.
- Then performs the single-cycle read or write on `anabellek` and returns a one-cycle completion pulse.
- The processor uses `islemci_hazir` as the stall/advance condition for memory-using stages.

Parameters:
- ADRES_BIT, 32, address width.
- VERI_BIT, 32, data width.
- BEKLEME, 3, fixed wait cycles before the access, legal range 0..15.
- LFSR_TOHUM, 16'hACE1, LFSR reset seed; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- islemci_istek  in  1  request valid; sampled only in BOSTA.
- islemci_yaz  in  1  1 = write, 0 = read; sampled with istek.
- islemci_adres  in  ADRES_BIT  byte address; sampled with istek.
- islemci_yaz_veri  in  VERI_BIT  write data; sampled with istek.
- islemci_oku_veri  out  VERI_BIT  registered read data of the last completed read.
- islemci_hazir  out  1  one-cycle pulse, access complete.
- mesgul  out  1  high in BEKLE and TAMAM.
- bellek_adres  out  ADRES_BIT  latched address to anabellek.
- bellek_yaz_veri  out  VERI_BIT  latched write data to anabellek.
- bellek_yaz  out  1  write strobe to anabellek; exactly one cycle per write.
- bellek_oku_veri  in  VERI_BIT  combinational read data from anabellek.

Behaviour:
- Reset values (async, applied immediately on rst, not at the next edge):
  - state = BOSTA, islemci_hazir = 0, bellek_yaz = 0, mesgul = 0.
  - islemci_oku_veri = 0, bellek_yaz_veri = 0, bellek_adres = 32'h8000_0000, wait counter = 0.
- FSM has 3 states: BOSTA, BEKLE, TAMAM.
- BOSTA:
  - If islemci_istek = 1 at the edge: latch adres, yaz and yaz_veri into bellek_adres and bellek_yaz_veri (this is the acceptance edge).
  - On the same edge: load the 5-bit counter with BEKLEME, then go to BEKLE.
  - Otherwise stay in BOSTA; bellek_adres keeps its last value.
- BEKLE, counter != 0: decrement, stay in BEKLE.
- BEKLE, counter == 0:
  - Write: bellek_yaz = 1 combinationally for this one cycle.
  - Read: capture bellek_oku_veri into islemci_oku_veri at the closing edge.
  - Go to TAMAM.
- TAMAM: islemci_hazir = 1 for exactly this cycle, then go to BOSTA. islemci_istek is ignored in TAMAM.
- Latency:
  - islemci_hazir goes high BEKLEME+1 cycles after the acceptance edge.
  - Back-to-back throughput is one access per BEKLEME+3 cycles.
- Latching:
  - Changes on adres, yaz, yaz_veri or istek after acceptance are ignored.
  - Dropping istek mid-BEKLE does not abort the access.
- islemci_oku_veri changes only on a completed read; it holds through writes and idle cycles.
- bellek_yaz is never high outside BEKLE with counter == 0.
- Reset mid-operation: the access is aborted.
  - No write strobe is issued afterwards.
  - No hazir pulse is issued.
  - Memory contents are unchanged.
- Counter arithmetic is 5-bit unsigned with no wrap; its maximum load is 18.
- Address or alignment checks are not done here; the address is passed through unchanged.

Optional Feature:
- Macro: RASTGELE_GECIKME_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11) is reset to LFSR_TOHUM.
  - The LFSR advances every clock.
  - At acceptance the counter loads BEKLEME + lfsr[1:0], giving latency BEKLEME+1..BEKLEME+4.
  - The latency sequence is deterministic after each reset.
- Undefined: no LFSR is instantiated; the counter loads BEKLEME exactly.

Test Plan:
- Read, BEKLEME=3, mem[0x8000_0200]=0x200: istek, yaz=0 accepted at edge N -> hazir high only in the cycle after edge N+4, islemci_oku_veri=0x200, bellek_yaz never high.
- Write, adres 0x8000_0300, data 0xFF003301 -> bellek_yaz high exactly one cycle with bellek_adres=0x8000_0300; mem reads back 0xFF003301; islemci_oku_veri unchanged.
- BEKLEME=0, five back-to-back reads of 0x8000_0200..0x8000_0210 (istek held high) -> hazir one cycle after each acceptance, data 0x200,0x400,0x800,0xC00,0x1000, all done in 15 cycles.
- Inputs changed mid-BEKLE (adres to 0x8000_0400, yaz_veri to 0) -> access uses the originally latched address and data.
- rst pulsed during BEKLE of a write to 0x8000_0300 -> outputs at reset values immediately, bellek_yaz never asserted, mem[0x8000_0300] unchanged, next request works normally.
- RASTGELE_GECIKME_EN defined, 32 reads -> every latency within 4..7 cycles, at least two distinct latencies, identical latency sequence after re-reset.
